// File: rtl/mole_round_datapath.sv
// mole_round_datapath: round/score datapath for the whack-a-mole game.
// Each window picks a pseudo-random hole, raises the mole for a fixed number
// of cycles, and scores a whack or counts a miss. game_over is raised once
// MAX_MISSES windows have expired without a whack.
// Ports:
//   clk          system clock, rising edge
//   Reset        asynchronous, active-low reset
//   start        1-cycle pulse, begin a new game (honoured in IDLE/OVER only)
//   valid_whack  level from control FSM; its rising edge during UP is a hit
//   mole_onehot  one-hot raised hole, 0 when no mole (combinational)
//   hit          1-cycle pulse, window ended by a whack
//   miss         1-cycle pulse, window expired
//   score        saturating hit count for this game
//   misses       missed windows this game
//   game_over    held high until the next start
module mole_round_datapath #(
  parameter int unsigned N_HOLES       = 4,
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter int unsigned MAX_MISSES    = 3,
  parameter int unsigned SCORE_W       = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               valid_whack,
  output logic [N_HOLES-1:0] mole_onehot,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               game_over
);

  localparam int unsigned HOLE_W  = $clog2(N_HOLES);
  localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [3:0]         MISS_LIMIT = 4'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_UP,
    S_HIT,
    S_MISS,
    S_OVER
  } state_t;

  state_t              state, state_d;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic [HOLE_W-1:0]   hole, hole_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic                whack_q;
  logic                whack_rise;
  logic [SCORE_W-1:0]  score_d;
  logic [3:0]          misses_d;
  logic [3:0]          misses_inc;
  logic                hit_d, miss_d, game_over_d;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign whack_rise = valid_whack & ~whack_q;
  assign misses_inc = misses + 4'd1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_SEED;
      hole      <= '0;
      timer     <= '0;
      whack_q   <= 1'b0;
      score     <= '0;
      misses    <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= {lfsr[14:0], lfsr_fb};
      hole      <= hole_d;
      timer     <= timer_d;
      whack_q   <= valid_whack;
      score     <= score_d;
      misses    <= misses_d;
      hit       <= hit_d;
      miss      <= miss_d;
      game_over <= game_over_d;
    end
  end

  // Next-state and next-value logic; hit/miss/game_over are set on entry
  // to HIT/MISS/OVER so the registered pulses line up with those states.
  always_comb begin
    state_d     = state;
    hole_d      = hole;
    timer_d     = timer;
    score_d     = score;
    misses_d    = misses;
    game_over_d = game_over;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        hole_d  = lfsr[HOLE_W-1:0];
        timer_d = TIMER_LOAD;
        state_d = S_UP;
      end
      S_UP: begin
        // A whack on the final cycle still wins over expiry.
        if (whack_rise) begin
          hit_d   = 1'b1;
          state_d = S_HIT;
        end else if (timer == '0) begin
          miss_d  = 1'b1;
          state_d = S_MISS;
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end
      S_HIT: begin
        if (score != SCORE_MAX) begin
          score_d = score + SCORE_W'(1);
        end
        state_d = S_ARM;
      end
      S_MISS: begin
        misses_d = misses_inc;
        if (misses_inc == MISS_LIMIT) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          state_d = S_ARM;
        end
      end
      S_OVER: begin
        if (start) begin
          score_d     = '0;
          misses_d    = '0;
          game_over_d = 1'b0;
          state_d     = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mole decode: only raised while the window is open.
  always_comb begin
    mole_onehot = '0;
    if (state == S_UP) begin
      mole_onehot = N_HOLES'(1) << hole;
    end
  end

endmodule

// File: tb/tb_mole_round_datapath.sv
module tb_mole_round_datapath;

  logic       clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       valid_whack;
  logic [3:0] mole_onehot, mole2;
  logic       hit, miss, game_over, hit2, miss2, game_over2;
  logic [7:0] score;
  logic [1:0] score2;
  logic [3:0] misses, misses2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_hole;
  logic [3:0]  exp_mole;

  always #5 clk = ~clk;

  mole_round_datapath #(
    .N_HOLES(4), .WINDOW_CYCLES(8), .MAX_MISSES(3), .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .Reset(Reset), .start(start), .valid_whack(valid_whack),
    .mole_onehot(mole_onehot), .hit(hit), .miss(miss), .score(score),
    .misses(misses), .game_over(game_over)
  );

  mole_round_datapath #(
    .N_HOLES(4), .WINDOW_CYCLES(8), .MAX_MISSES(3), .SCORE_W(2), .LFSR_SEED(16'hACE1)
  ) dut2 (
    .clk(clk), .Reset(Reset), .start(start), .valid_whack(valid_whack),
    .mole_onehot(mole2), .hit(hit2), .miss(miss2), .score(score2),
    .misses(misses2), .game_over(game_over2)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11, new bit enters at the LSB.
  always @(posedge clk or negedge Reset) begin
    if (!Reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start       = 1'b0;
    valid_whack = 1'b0;
    Reset       = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
  endtask

  // Pulse start from IDLE/OVER; returns at the negedge of the ARM cycle.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From the ARM cycle, walk n UP cycles, optionally raising valid_whack in
  // UP cycle rise_at; good counts cycles where both moles show the hole.
  task automatic run_up(input int rise_at, input int n, output int good);
    exp_hole = m_lfsr[1:0];
    exp_mole = 4'b0001 << exp_hole;
    good = 0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (rise_at == c) valid_whack = 1'b1;
      if (mole_onehot === exp_mole && mole2 === exp_mole) good++;
    end
  endtask

  task automatic test_reset();
    int g;
    start = 1'b0; valid_whack = 1'b0; Reset = 1'b0;
    #1;
    n_checks++; if (mole_onehot !== 4'b0 || hit !== 1'b0 || miss !== 1'b0) begin n_fail++; $display("FAIL reset_outs: mole=%b hit=%b miss=%b required 0000/0/0", mole_onehot, hit, miss); end
    n_checks++; if (score !== 8'd0 || misses !== 4'd0 || game_over !== 1'b0) begin n_fail++; $display("FAIL reset_counts: score=%0d misses=%0d go=%b required 0/0/0", score, misses, game_over); end
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (mole_onehot !== 4'b0) begin n_fail++; $display("FAIL idle_mole: got %b required 0000", mole_onehot); end
    do_start();
    run_up(1, 1, g);
    tick();
    valid_whack = 1'b0;
    tick();
    run_up(0, 4, g);
    n_checks++; if (g !== 4) begin n_fail++; $display("FAIL reset_pre_up: good cycles %0d required 4", g); end
    n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL reset_pre_score: got %0d required 1", score); end
    n_checks++; if (dut.lfsr !== m_lfsr) begin n_fail++; $display("FAIL lfsr_seq: got %h required %h", dut.lfsr, m_lfsr); end
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (mole_onehot !== 4'b0 || hit !== 1'b0 || miss !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL midup_outs: mole=%b hit=%b miss=%b go=%b required all 0", mole_onehot, hit, miss, game_over); end
    n_checks++; if (score !== 8'd0 || misses !== 4'd0) begin n_fail++; $display("FAIL midup_counts: score=%0d misses=%0d required 0/0", score, misses); end
    n_checks++; if (dut.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL midup_lfsr: got %h required ace1", dut.lfsr); end
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (mole_onehot !== 4'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b required 0000", mole_onehot); end
  endtask

  task automatic test_miss();
    int g;
    do_reset();
    do_start();
    n_checks++; if (mole_onehot !== 4'b0) begin n_fail++; $display("FAIL arm_mole: got %b required 0000", mole_onehot); end
    for (int w = 1; w <= 3; w++) begin
      exp_hole = m_lfsr[1:0];
      exp_mole = 4'b0001 << exp_hole;
      g = 0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        // A start mid-window must be ignored.
        start = (w == 2 && c == 4);
        if (mole_onehot === exp_mole) g++;
      end
      start = 1'b0;
      n_checks++; if (g !== 8) begin n_fail++; $display("FAIL miss_window%0d: good cycles %0d required 8", w, g); end
      tick();
      n_checks++; if (miss !== 1'b1 || miss2 !== 1'b1 || hit !== 1'b0 || mole_onehot !== 4'b0) begin n_fail++; $display("FAIL miss_pulse%0d: miss=%b hit=%b mole=%b required 1/0/0000", w, miss, hit, mole_onehot); end
      tick();
      n_checks++; if (misses !== 4'(w) || miss !== 1'b0) begin n_fail++; $display("FAIL miss_count%0d: misses=%0d miss=%b required %0d/0", w, misses, miss, w); end
    end
    n_checks++; if (game_over !== 1'b1 || score !== 8'd0 || mole_onehot !== 4'b0) begin n_fail++; $display("FAIL over: go=%b score=%0d mole=%b required 1/0/0000", game_over, score, mole_onehot); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (game_over !== 1'b1 || mole_onehot !== 4'b0 || misses !== 4'd3) begin n_fail++; $display("FAIL over_hold: go=%b mole=%b misses=%0d required 1/0000/3", game_over, mole_onehot, misses); end
  endtask

  task automatic test_hit();
    int g;
    do_reset();
    do_start();
    run_up(3, 3, g);
    n_checks++; if (g !== 3) begin n_fail++; $display("FAIL hit_up: good cycles %0d required 3", g); end
    tick();
    valid_whack = 1'b0;
    n_checks++; if (hit !== 1'b1 || hit2 !== 1'b1 || miss !== 1'b0 || mole_onehot !== 4'b0) begin n_fail++; $display("FAIL hit_pulse: hit=%b miss=%b mole=%b required 1/0/0000", hit, miss, mole_onehot); end
    tick();
    n_checks++; if (hit !== 1'b0 || score !== 8'd1 || misses !== 4'd0) begin n_fail++; $display("FAIL hit_score: hit=%b score=%0d misses=%0d required 0/1/0", hit, score, misses); end
    run_up(0, 1, g);
    n_checks++; if (g !== 1) begin n_fail++; $display("FAIL hit_next_window: good cycles %0d required 1", g); end
  endtask

  task automatic test_last_cycle_whack();
    int g;
    do_reset();
    do_start();
    run_up(8, 8, g);
    n_checks++; if (g !== 8) begin n_fail++; $display("FAIL edge_up: good cycles %0d required 8", g); end
    tick();
    valid_whack = 1'b0;
    n_checks++; if (hit !== 1'b1 || miss !== 1'b0) begin n_fail++; $display("FAIL edge_pulse: hit=%b miss=%b required 1/0", hit, miss); end
    tick();
    n_checks++; if (misses !== 4'd0 || score !== 8'd1) begin n_fail++; $display("FAIL edge_counts: misses=%0d score=%0d required 0/1", misses, score); end
  endtask

  task automatic test_held_whack();
    int g;
    do_reset();
    do_start();
    run_up(2, 2, g);
    tick();
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL held_first_hit: hit=%b required 1", hit); end
    tick();
    for (int w = 0; w < 2; w++) begin
      run_up(0, 8, g);
      n_checks++; if (g !== 8) begin n_fail++; $display("FAIL held_window%0d: good cycles %0d required 8", w, g); end
      tick();
      n_checks++; if (miss !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL held_miss%0d: miss=%b hit=%b required 1/0", w, miss, hit); end
      tick();
    end
    n_checks++; if (score !== 8'd1 || misses !== 4'd2 || game_over !== 1'b0) begin n_fail++; $display("FAIL held_counts: score=%0d misses=%0d go=%b required 1/2/0", score, misses, game_over); end
    valid_whack = 1'b0;
  endtask

  task automatic test_saturate_restart();
    int g;
    do_reset();
    do_start();
    for (int w = 0; w < 5; w++) begin
      run_up(1, 1, g);
      tick();
      valid_whack = 1'b0;
      tick();
    end
    n_checks++; if (score2 !== 2'd3) begin n_fail++; $display("FAIL sat_score2: got %0d required 3", score2); end
    n_checks++; if (score !== 8'd5) begin n_fail++; $display("FAIL sat_score8: got %0d required 5", score); end
    for (int w = 0; w < 3; w++) begin
      run_up(0, 8, g);
      tick();
      tick();
    end
    n_checks++; if (game_over2 !== 1'b1 || misses2 !== 4'd3 || score2 !== 2'd3) begin n_fail++; $display("FAIL sat_over: go=%b misses=%0d score=%0d required 1/3/3", game_over2, misses2, score2); end
    do_start();
    n_checks++; if (score2 !== 2'd0 || score !== 8'd0 || misses2 !== 4'd0 || game_over2 !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL restart: score2=%0d score=%0d misses=%0d go=%b required 0/0/0/0", score2, score, misses2, game_over2); end
    run_up(0, 1, g);
    n_checks++; if (g !== 1) begin n_fail++; $display("FAIL restart_window: good cycles %0d required 1", g); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_last_cycle_whack();
    test_held_whack();
    test_saturate_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
